// File: rtl/pcap_stream_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pcap_stream_arbiter: packet-granular round-robin merge of N AXI4-Stream   |
// | sources into one pcap dumper stream, with sticky end-of-stream.           |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module pcap_stream_arbiter #(
  parameter int N_PORTS    = 4,
  parameter int AXIS_WIDTH = 64,
  parameter int SRC_W      = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [N_PORTS*AXIS_WIDTH-1:0]  s_tdata,
  input  logic [N_PORTS*AXIS_WIDTH/8-1:0] s_tstrb,
  input  logic [N_PORTS-1:0]             s_tvalid,
  input  logic [N_PORTS-1:0]             s_tlast,
  output logic [N_PORTS-1:0]             s_tready,
  input  logic [N_PORTS-1:0]             s_eos,
  output logic [AXIS_WIDTH-1:0]          m_tdata,
  output logic [AXIS_WIDTH/8-1:0]        m_tstrb,
  output logic                           m_tvalid,
  output logic                           m_tlast,
  input  logic                           m_tready,
  output logic [SRC_W-1:0]               m_src,
  output logic                           m_eos,
  output logic [31:0]                    pkt_total
);

  localparam int STRB_W = AXIS_WIDTH / 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PASS     = 2'd1,
    ST_FINISHED = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [SRC_W-1:0]     grant_q, grant_d;
  logic [SRC_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [N_PORTS-1:0]   done_q, done_d;
  logic [31:0]          pkt_total_q, pkt_total_d;

  logic [AXIS_WIDTH-1:0] tdata_a [N_PORTS];
  logic [STRB_W-1:0]     tstrb_a [N_PORTS];

  for (genvar i = 0; i < N_PORTS; i++) begin : g_unpack
    assign tdata_a[i] = s_tdata[i*AXIS_WIDTH +: AXIS_WIDTH];
    assign tstrb_a[i] = s_tstrb[i*STRB_W +: STRB_W];
  end

  // Round-robin search: first valid port at or above rr_ptr, wrapping.
  int               arb_idx;
  logic             win_found;
  logic [SRC_W-1:0] win_idx;

  always_comb begin
    arb_idx   = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      arb_idx = (int'(rr_ptr_q) + k) % N_PORTS;
      if (!win_found && s_tvalid[arb_idx[SRC_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = arb_idx[SRC_W-1:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    pkt_total_d = pkt_total_q;
    done_d      = done_q | s_eos;
    m_tdata     = '0;
    m_tstrb     = '0;
    m_tvalid    = 1'b0;
    m_tlast     = 1'b0;
    s_tready    = '0;

    case (state_q)
      ST_IDLE: begin
        // A pending packet always beats end-of-stream so every source drains.
        if (win_found) begin
          grant_d = win_idx;
          state_d = ST_PASS;
        end else if (&done_q) begin
          state_d = ST_FINISHED;
        end
      end
      ST_PASS: begin
        m_tdata            = tdata_a[grant_q];
        m_tstrb            = tstrb_a[grant_q];
        m_tvalid           = s_tvalid[grant_q];
        m_tlast            = s_tlast[grant_q];
        s_tready[grant_q]  = m_tready;
        if (m_tvalid && m_tready && m_tlast) begin
          pkt_total_d = pkt_total_q + 32'd1;
          rr_ptr_d    = (grant_q == SRC_W'(N_PORTS - 1)) ? '0 : grant_q + SRC_W'(1);
          state_d     = ST_IDLE;
        end
      end
      ST_FINISHED: begin
        state_d = ST_FINISHED;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      done_q      <= '0;
      pkt_total_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      done_q      <= done_d;
      pkt_total_q <= pkt_total_d;
    end
  end

  assign m_src     = grant_q;
  assign m_eos     = (state_q == ST_FINISHED);
  assign pkt_total = pkt_total_q;

endmodule
`default_nettype wire

// File: tb/tb_pcap_stream_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pcap_stream_arbiter: directed and randomized bench for the arbiter.    |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_pcap_stream_arbiter;

  localparam int N  = 4;
  localparam int W  = 64;
  localparam int SW = W / 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N*W-1:0]  s_tdata;
  logic [N*SW-1:0] s_tstrb;
  logic [N-1:0]    s_tvalid, s_tlast, s_tready, s_eos;
  logic [W-1:0]    m_tdata;
  logic [SW-1:0]   m_tstrb;
  logic            m_tvalid, m_tlast, m_tready;
  logic [1:0]      m_src;
  logic            m_eos;
  logic [31:0]     pkt_total;

  pcap_stream_arbiter #(.N_PORTS(N), .AXIS_WIDTH(W), .SRC_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_tdata(s_tdata), .s_tstrb(s_tstrb), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .s_tready(s_tready), .s_eos(s_eos),
    .m_tdata(m_tdata), .m_tstrb(m_tstrb), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
    .m_tready(m_tready), .m_src(m_src), .m_eos(m_eos), .pkt_total(pkt_total)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    src;
    logic [W-1:0]  data;
    logic [SW-1:0] strb;
    logic          last;
  } beat_t;

  beat_t       srcq [N][$];
  beat_t       expq [$];
  bit          first_beat [N];
  int          checks = 0;
  int          errors = 0;
  int          model_ptr, exp_pkts, bytes, cyc;
  int          last_times [$];
  bit          gap_en;
  int          tr_mode;
  logic [N-1:0] eos_next;
  logic        last_mvalid, last_eos;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_beat(input int p, input logic [SW-1:0] strb, input logic last);
    beat_t b;
    b.src  = 2'(p);
    b.data = {$urandom, $urandom};
    b.strb = strb;
    b.last = last;
    srcq[p].push_back(b);
  endtask

  task automatic load_pkt(input int p, input int n);
    logic [SW-1:0] s;
    for (int i = 0; i < n; i++) begin
      s = ($urandom_range(0, 4) == 0) ? '0 : SW'($urandom);
      load_beat(p, s, i == n - 1);
    end
  endtask

  // Packet-level model: every loaded source offers its next packet at once,
  // so the merged order is plain round robin over non-empty packet lists.
  task automatic plan();
    beat_t tmp [N][$];
    beat_t b;
    int    w;
    for (int i = 0; i < N; i++) tmp[i] = srcq[i];
    while (1) begin
      w = -1;
      for (int k = 0; k < N; k++)
        if (w < 0 && tmp[(model_ptr + k) % N].size() > 0) w = (model_ptr + k) % N;
      if (w < 0) break;
      do begin
        b = tmp[w].pop_front();
        expq.push_back(b);
      end while (!b.last);
      model_ptr = (w + 1) % N;
      exp_pkts++;
    end
  endtask

  task automatic drive();
    beat_t b;
    for (int p = 0; p < N; p++) begin
      if (srcq[p].size() > 0) begin
        b = srcq[p][0];
        s_tdata[p*W +: W]   = b.data;
        s_tstrb[p*SW +: SW] = b.strb;
        s_tlast[p]          = b.last;
        s_tvalid[p]         = (first_beat[p] || !gap_en) ? 1'b1 : ($urandom_range(0, 3) != 0);
      end else begin
        s_tdata[p*W +: W]   = {$urandom, $urandom};
        s_tstrb[p*SW +: SW] = SW'($urandom);
        s_tlast[p]          = 1'($urandom);
        s_tvalid[p]         = 1'b0;
      end
    end
    s_eos    = eos_next;
    eos_next = '0;
    case (tr_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = ~m_tready;
      default: m_tready = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  task automatic sample();
    beat_t e, b;
    last_mvalid = m_tvalid;
    last_eos    = m_eos;
    if (expq.size() > 0)
      chk("tready_excl", 64'(s_tready & ~(N'(1) << expq[0].src)), 0);
    if (m_tvalid && m_tready) begin
      chk("beat_expected", 64'(expq.size() != 0), 1);
      if (expq.size() != 0) begin
        e = expq.pop_front();
        chk("m_src", 64'(m_src), 64'(e.src));
        chk("m_tdata", m_tdata, e.data);
        chk("m_tstrb", 64'(m_tstrb), 64'(e.strb));
        chk("m_tlast", 64'(m_tlast), 64'(e.last));
        bytes += $countones(m_tstrb);
        if (m_tlast) last_times.push_back(cyc);
      end
    end
    for (int p = 0; p < N; p++) begin
      if (s_tvalid[p] && s_tready[p] && srcq[p].size() > 0) begin
        b = srcq[p].pop_front();
        first_beat[p] = b.last;
      end
    end
    cyc++;
  endtask

  task automatic cycle();
    drive();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (expq.size() > 0 && n < 3000) begin
      cycle();
      n++;
    end
    chk({tag, "_drain"}, 64'(expq.size()), 0);
  endtask

  task automatic clear_sources();
    for (int p = 0; p < N; p++) begin
      srcq[p].delete();
      first_beat[p] = 1'b1;
    end
    expq.delete();
  endtask

  task automatic apply_reset();
    rst_n    = 1'b0;
    clear_sources();
    s_tvalid = '1;
    s_tlast  = '1;
    s_tdata  = {N*2{$urandom}};
    s_tstrb  = '1;
    s_eos    = '0;
    eos_next = '0;
    m_tready = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_m_tvalid", 64'(m_tvalid), 0);
    chk("rst_m_tlast", 64'(m_tlast), 0);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_m_tstrb", 64'(m_tstrb), 0);
    chk("rst_m_src", 64'(m_src), 0);
    chk("rst_m_eos", 64'(m_eos), 0);
    chk("rst_s_tready", 64'(s_tready), 0);
    chk("rst_pkt_total", 64'(pkt_total), 0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    s_tvalid  = '0;
    model_ptr = 0;
    exp_pkts  = 0;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc = 0; bytes = 0; gap_en = 0; tr_mode = 0;
    s_tvalid = '0; s_tlast = '0; s_tdata = '0; s_tstrb = '0; s_eos = '0; m_tready = 1'b1;
    eos_next = '0;
    apply_reset();

    // Single port, 3 beats, 20 valid bytes
    load_beat(2, 8'hFF, 1'b0);
    load_beat(2, 8'hFF, 1'b0);
    load_beat(2, 8'h0F, 1'b1);
    plan();
    bytes = 0;
    cycle();
    chk("t1_bubble", 64'(last_mvalid), 0);
    cycle();
    chk("t1_first_valid", 64'(last_mvalid), 1);
    chk("t1_src", 64'(m_src), 2);
    drain("t1");
    chk("t1_bytes", 64'(bytes), 20);
    chk("t1_pkt_total", 64'(pkt_total), 64'(exp_pkts));

    // Round robin, 1-beat packets from all ports
    apply_reset();
    for (int p = 0; p < N; p++) begin
      load_pkt(p, 1);
      load_pkt(p, 1);
    end
    plan();
    last_times.delete();
    drain("t2");
    chk("t2_npkts", 64'(last_times.size()), 8);
    for (int i = 1; i < last_times.size(); i++)
      chk("t2_rr_gap", 64'(last_times[i] - last_times[i-1]), 2);
    chk("t2_pkt_total", 64'(pkt_total), 8);

    // Backpressure: port 0 mid-packet, port 1 waiting
    tr_mode = 1;
    load_pkt(0, 4);
    load_pkt(1, 2);
    plan();
    drain("t3");
    chk("t3_pkt_total", 64'(pkt_total), 64'(exp_pkts));
    tr_mode = 0;

    // Reset during 2nd of 4 beats from port 1
    load_pkt(1, 4);
    plan();
    cycle();
    cycle();
    drive();
    #1;
    chk("t5_pre_valid", 64'(m_tvalid), 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_m_tvalid", 64'(m_tvalid), 0);
    chk("t5_rst_s_tready", 64'(s_tready), 0);
    chk("t5_rst_pkt_total", 64'(pkt_total), 0);
    clear_sources();
    s_tvalid = '0;
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    model_ptr = 0;
    exp_pkts  = 0;
    load_pkt(3, 1);
    load_pkt(1, 1);
    plan();
    drain("t5");
    chk("t5_pkt_total", 64'(pkt_total), 2);

    // Partial end-of-stream never finishes
    eos_next = 4'b0111;
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("t6_eos_low", 64'(last_eos), 0);
    end
    eos_next = 4'b1000;
    cycle();
    cycle();
    cycle();
    chk("t6_eos_high", 64'(last_eos), 1);

    // End-of-stream while port 3 still has a packet pending
    apply_reset();
    load_pkt(3, 2);
    plan();
    eos_next = 4'hF;
    drain("t4");
    chk("t4_pkt_total", 64'(pkt_total), 1);
    cycle();
    chk("t4_eos_idle", 64'(last_eos), 0);
    cycle();
    chk("t4_eos_rise", 64'(last_eos), 1);
    load_pkt(0, 1);
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("t4_eos_hold", 64'(last_eos), 1);
      chk("t4_no_valid", 64'(last_mvalid), 0);
      chk("t4_no_ready", 64'(s_tready), 0);
    end

    // Randomized traffic with valid gaps and random backpressure
    apply_reset();
    gap_en  = 1;
    tr_mode = 2;
    for (int it = 0; it < 6; it++) begin
      for (int p = 0; p < N; p++) begin
        int npk;
        npk = $urandom_range(0, 3);
        for (int k = 0; k < npk; k++) load_pkt(p, $urandom_range(1, 5));
      end
      plan();
      drain("rand");
      chk("rand_pkt_total", 64'(pkt_total), 64'(exp_pkts));
    end
    eos_next = 4'hF;
    cycle();
    cycle();
    cycle();
    chk("rand_final_eos", 64'(last_eos), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pcap_stream_arbiter.md
Name: pcap_stream_arbiter

Overview:
- Merges N independent AXI4-Stream packet sources into the single stream consumed by the pcap dumper.
- Arbitrates round-robin at packet granularity, so packets are never interleaved in the capture file.
- Generates the dumper's end-of-stream (eos) once every source has declared completion and all traffic has drained.
- Sits between the testbench traffic generators / DUT ports and the pcap dumper instance.

Parameters:
- N_PORTS, 4, number of input streams (2..16).
- AXIS_WIDTH, 64, tdata width in bits (multiple of 8).
- SRC_W, 2, width of m_src; must equal clog2(N_PORTS).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- s_tdata  in  N_PORTS*AXIS_WIDTH  input data; port i occupies slice [i*AXIS_WIDTH +: AXIS_WIDTH].
- s_tstrb  in  N_PORTS*AXIS_WIDTH/8  byte strobes; sliced per port in the same way as s_tdata.
- s_tvalid  in  N_PORTS  per-port valid.
- s_tlast  in  N_PORTS  per-port end of packet.
- s_tready  out  N_PORTS  per-port ready.
- s_eos  in  N_PORTS  per-port "no more packets" pulse or level.
- m_tdata  out  AXIS_WIDTH  merged data.
- m_tstrb  out  AXIS_WIDTH/8  merged strobes.
- m_tvalid  out  1  merged valid.
- m_tlast  out  1  merged last.
- m_tready  in  1  downstream ready.
- m_src  out  SRC_W  index of the currently granted port.
- m_eos  out  1  end of stream to the dumper; sticky.
- pkt_total  out  32  packets forwarded.

Behaviour:
Reset (asynchronous, rst_n=0):
- state=IDLE, rr_ptr=0, done_flags=0.
- m_tvalid=0, m_tlast=0, m_tdata=0, m_tstrb=0, m_src=0, m_eos=0, s_tready=0, pkt_total=0.
- Reset mid-packet discards the remainder of the grant; the partial packet is not completed.

State machine, IDLE / PASS / FINISHED:

IDLE:
- s_tready=0, m_tvalid=0.
- Eligible set = s_tvalid.
- If non-empty: the winner is the first set bit searching upward from rr_ptr, wrapping modulo N_PORTS. Register grant=winner and m_src=winner; next state is PASS.
- Otherwise, if done_flags are all 1: next state is FINISHED.
- Exactly one bubble cycle per packet is spent in IDLE.

PASS:
- Pure combinational pass-through from the granted port: m_tdata, m_tstrb, m_tvalid, m_tlast = s_*[grant].
- s_tready[grant]=m_tready; all other s_tready bits are 0.
- Beat transfers when m_tvalid && m_tready.
- On a transferred beat with m_tlast=1:
  - pkt_total increments, wrapping at 2^32.
  - rr_ptr = grant+1 mod N_PORTS.
  - next state is IDLE.
- Valid deasserting mid-packet keeps the grant; no timeout.
- Beats with tstrb=0 are forwarded unchanged.

FINISHED:
- m_eos=1 and held until reset.
- All s_tready=0, m_tvalid=0.
- No exit except reset.

done_flags:
- done_flags[i] is set on any cycle where s_eos[i]=1, in any state.
- Cleared only by reset.
- A port with done_flags set remains eligible if it still presents tvalid, so it drains.
- If eos is asserted while its port is mid-packet, the packet completes normally.

Outputs and combinational paths:
- m_src is valid whenever state=PASS and holds its last value otherwise.
- No combinational path from m_tready to m_tvalid.
- s_tready depends combinationally on m_tready only in PASS.

Simultaneous events:
- s_eos and s_tvalid on the same port in IDLE: the grant wins; FINISHED is evaluated only when the eligible set is empty.

Test Plan:
- Single-port packet: port 2 sends 3 beats (tstrb FF, FF, 0F, tlast on beat 3) with m_tready=1.
  - Expect m_src=2, 20 bytes forwarded unchanged, pkt_total=1.
  - First m_tvalid appears 1 cycle after s_tvalid rises.
- Round-robin fairness: all 4 ports continuously offer 1-beat packets.
  - Expect grant order 0,1,2,3,0,1 with one IDLE cycle between grants.
  - After 8 packets, pkt_total=8.
- No interleave under backpressure: port 0 is mid-packet, m_tready toggles every cycle, port 1 is valid throughout.
  - Expect s_tready[1]=0 until port 0's tlast transfers.
  - Port 0's beats arrive in order; port 1 is granted next.
- EOS sequencing: ports 0–3 pulse s_eos while port 3 still has a 2-beat packet pending.
  - Expect the packet to be forwarded first.
  - m_eos rises exactly 1 cycle after returning to IDLE with no valid inputs, then stays 1.
- Reset mid-packet: assert rst_n=0 on the 2nd of 4 beats from port 1.
  - Expect m_tvalid, s_tready, and pkt_total to go to 0 immediately.
  - After release, the next arbitration starts from rr_ptr=0.
- Partial EOS: only ports 0–2 assert s_eos.
  - Expect m_eos=0 indefinitely while idle.
  - After port 3 asserts s_eos, m_eos=1 within 2 cycles.
